// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Floor index width; never narrower than one bit.
  function automatic int fw(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational call scan relative to a floor: call here, calls above/below,
// and whether any call lies strictly beyond that floor in the given direction.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter  int NFLOORS = 4,
  localparam int FW      = fw(NFLOORS)
) (
  input  logic [NFLOORS-1:0] req,
  input  logic [FW-1:0]      floor,
  input  logic               dir,
  output logic               here,
  output logic               above,
  output logic               below,
  output logic               beyond_next
);

  // Partition call lines into below / here / above the reference floor.
  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int j = 0; j < NFLOORS; j++) begin
      if (j > int'(floor)) begin
        above = above | req[j];
      end else if (j < int'(floor)) begin
        below = below | req[j];
      end else begin
        here = req[j];
      end
    end
    beyond_next = (dir == DIR_UP) ? above : below;
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// SCAN elevator car controller: moves one floor per MOVE_TICKS cycles, opens the
// door for DOOR_TICKS cycles at requested floors, and drives one-hot arrival feedback.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter  int NFLOORS    = 4,
  parameter  int MOVE_TICKS = 4,
  parameter  int DOOR_TICKS = 3,
  localparam int FW         = fw(NFLOORS)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NFLOORS-1:0] req,
  output logic [NFLOORS-1:0] fb,
  output logic [FW-1:0]      floor,
  output logic               dir,
  output logic               moving,
  output logic               door_open
);

  localparam int              CW        = $clog2(((MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS) + 1);
  localparam logic [CW-1:0]   MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0]   DOOR_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0]   TOP       = FW'(NFLOORS - 1);
  localparam logic [NFLOORS-1:0] ONE_HOT0 = {{(NFLOORS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NFLOORS-1:0]  fb_q, fb_d;
  logic                moving_q, moving_d;
  logic                door_open_q, door_open_d;

  logic [FW-1:0]       nf_s;
  logic [FW-1:0]       scan_floor_s;
  logic                here_s, above_s, below_s, beyond_s;

  // Next floor in the travel direction, clamped to the shaft.
  always_comb begin
    if (dir_q == DIR_UP) begin
      nf_s = (floor_q == TOP) ? floor_q : floor_q + FW'(1);
    end else begin
      nf_s = (floor_q == FW'(0)) ? floor_q : floor_q - FW'(1);
    end
  end

  // While moving, the single scanner looks ahead at the arrival floor.
  assign scan_floor_s = (state_q == MOVE) ? nf_s : floor_q;

  elevator_req_scan #(.NFLOORS(NFLOORS)) u_scan (
    .req         (req),
    .floor       (scan_floor_s),
    .dir         (dir_q),
    .here        (here_s),
    .above       (above_s),
    .below       (below_s),
    .beyond_next (beyond_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = CW'(0);
        if (here_s) begin
          state_d = DOOR;
        end else if (above_s && (dir_q == DIR_UP || !below_s)) begin
          dir_d   = DIR_UP;
          state_d = MOVE;
        end else if (below_s) begin
          dir_d   = DIR_DOWN;
          state_d = MOVE;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE: begin
        if (cnt_q == MOVE_LAST) begin
          floor_d = nf_s;
          cnt_d   = CW'(0);
          if (here_s) begin
            state_d = DOOR;
          end else if (beyond_s) begin
            state_d = MOVE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DOOR: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = IDLE;
          cnt_d   = CW'(0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CW'(0);
      end
    endcase

    moving_d    = (state_d == MOVE);
    door_open_d = (state_d == DOOR);
    if (state_d == DOOR) begin
      fb_d = ONE_HOT0 << floor_d;
    end else begin
      fb_d = '0;
    end
  end

  // State and registered outputs with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_q       <= DIR_UP;
      cnt_q       <= '0;
      fb_q        <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      fb_q        <= fb_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign fb        = fb_q;
  assign floor     = floor_q;
  assign dir       = dir_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed and randomized bench for elevator_car_ctrl against a timeline model
// of the car (mode + remaining-cycle timer), with the bench acting as the buttons.
module tb_elevator_car_ctrl;

  localparam int NF = 4;
  localparam int MT = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] req;
  logic [3:0] fb;
  logic [1:0] floor;
  logic       dir, moving, door_open;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = idle, 1 = travelling, 2 = door open.
  int m_mode, m_timer, m_floor;
  bit m_dir;

  logic [3:0] press;
  logic [3:0] prev_fb;
  logic [3:0] fb_log[$];

  always #5 clk = ~clk;

  elevator_car_ctrl #(.NFLOORS(NF), .MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .fb        (fb),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_fb();
    logic [3:0] one;
    one = 4'b0001;
    return (m_mode == 2) ? (one << m_floor) : 4'b0000;
  endfunction

  function automatic bit calls_beyond(input int f, input bit up);
    bit any;
    any = 1'b0;
    for (int j = 0; j < NF; j++) begin
      if (req[j] && (up ? (j > f) : (j < f))) any = 1'b1;
    end
    return any;
  endfunction

  task automatic model_step();
    bit ab, be;
    if (clr) begin
      m_mode = 0; m_floor = 0; m_dir = 1'b1; m_timer = 0;
    end else if (m_mode == 0) begin
      ab = calls_beyond(m_floor, 1'b1);
      be = calls_beyond(m_floor, 1'b0);
      if (req[m_floor]) begin
        m_mode = 2; m_timer = DT;
      end else if (ab && (m_dir || !be)) begin
        m_dir = 1'b1; m_mode = 1; m_timer = MT;
      end else if (be) begin
        m_dir = 1'b0; m_mode = 1; m_timer = MT;
      end
    end else if (m_mode == 1) begin
      m_timer--;
      if (m_timer == 0) begin
        m_floor = m_dir ? m_floor + 1 : m_floor - 1;
        if (req[m_floor]) begin
          m_mode = 2; m_timer = DT;
        end else if (calls_beyond(m_floor, m_dir)) begin
          m_timer = MT;
        end else begin
          m_mode = 0;
        end
      end
    end else begin
      m_timer--;
      if (m_timer == 0) m_mode = 0;
    end
  endtask

  // One clock: buttons latch presses / clear on feedback, edge, then compare.
  task automatic cycle();
    req   = clr ? 4'b0000 : ((req | press) & ~m_fb());
    press = 4'b0000;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("floor", 32'(floor), 32'(m_floor));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("moving", 32'(moving), 32'(m_mode == 1));
    chk("door_open", 32'(door_open), 32'(m_mode == 2));
    chk("fb", 32'(fb), 32'(m_fb()));
    chk("fb_onehot", 32'($countones(fb) <= 1), 32'(1));
    chk("fb_outside_door", 32'((fb != 4'b0000) && !door_open), 32'(0));
    if (fb != 4'b0000 && prev_fb == 4'b0000) fb_log.push_back(fb);
    prev_fb = fb;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    clr = 1'b1; req = 4'b0000; press = 4'b0000; prev_fb = 4'b0000;
    m_mode = 0; m_floor = 0; m_dir = 1'b1; m_timer = 0;
    run(2);
    clr = 1'b0;

    // Reset during a trip toward floor 2
    press = 4'b0100;
    run(6);
    chk("pre_rst_moving", 32'(moving), 32'(1));
    clr = 1'b1;
    run(2);
    chk("rst_floor", 32'(floor), 32'(0));
    chk("rst_dir", 32'(dir), 32'(1));
    chk("rst_fb", 32'(fb), 32'(4'b0000));
    chk("rst_moving", 32'(moving), 32'(0));
    chk("rst_door", 32'(door_open), 32'(0));
    clr = 1'b0;
    run(2);

    // Call at the current floor
    press = 4'b0001;
    cycle();
    chk("here_door1", 32'(door_open), 32'(1));
    chk("here_fb1", 32'(fb), 32'(4'b0001));
    run(2);
    chk("here_door3", 32'(door_open), 32'(1));
    cycle();
    chk("here_door_end", 32'(door_open), 32'(0));
    chk("here_fb_end", 32'(fb), 32'(4'b0000));
    run(2);

    // Single trip 0 -> 2
    press = 4'b0100;
    cycle();
    chk("trip_moving", 32'(moving), 32'(1));
    run(3);
    chk("trip_floor0", 32'(floor), 32'(0));
    cycle();
    chk("trip_floor1", 32'(floor), 32'(1));
    run(3);
    cycle();
    chk("trip_floor2", 32'(floor), 32'(2));
    chk("trip_door", 32'(door_open), 32'(1));
    chk("trip_fb", 32'(fb), 32'(4'b0100));
    run(12);

    // Back to floor 0, then SCAN from floor 1 moving up
    press = 4'b0001;
    run(20);
    chk("scan_start_floor", 32'(floor), 32'(0));
    press = 4'b1000;
    run(5);
    chk("scan_at1", 32'(floor), 32'(1));
    fb_log.delete();
    press = 4'b0101;
    run(60);
    chk("scan_count", 32'(fb_log.size()), 32'(3));
    if (fb_log.size() == 3) begin
      chk("scan_fb0", 32'(fb_log[0]), 32'(4'b0100));
      chk("scan_fb1", 32'(fb_log[1]), 32'(4'b1000));
      chk("scan_fb2", 32'(fb_log[2]), 32'(4'b0001));
    end
    chk("scan_end_dir", 32'(dir), 32'(0));

    // Tie-break: idle at floor 2 heading down with calls at 0 and 3
    press = 4'b1000;
    run(20);
    press = 4'b0100;
    run(12);
    chk("tie_floor", 32'(floor), 32'(2));
    chk("tie_dir", 32'(dir), 32'(0));
    fb_log.delete();
    press = 4'b1001;
    run(50);
    chk("tie_count", 32'(fb_log.size()), 32'(2));
    if (fb_log.size() == 2) begin
      chk("tie_fb0", 32'(fb_log[0]), 32'(4'b0001));
      chk("tie_fb1", 32'(fb_log[1]), 32'(4'b1000));
    end

    // Top floor reversal
    chk("top_floor", 32'(floor), 32'(3));
    chk("top_dir", 32'(dir), 32'(1));
    fb_log.delete();
    press = 4'b0010;
    cycle();
    chk("top_rev_dir", 32'(dir), 32'(0));
    chk("top_rev_moving", 32'(moving), 32'(1));
    run(20);
    chk("top_count", 32'(fb_log.size()), 32'(1));
    if (fb_log.size() == 1) chk("top_fb", 32'(fb_log[0]), 32'(4'b0010));
    chk("top_end_floor", 32'(floor), 32'(1));

    // Random calls with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) press = 4'b0001 << $urandom_range(0, 3);
      clr = ($urandom_range(0, 299) == 0);
      cycle();
    end
    clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
- Car-side controller for the elevator lab design.
- Consumes the latched per-floor call levels produced by the floor button blocks.
- Moves the car one floor at a time using a SCAN policy, which keeps the current direction while calls remain ahead.
- Drives a per-floor arrival feedback line back to the buttons, which clears their latched calls.

Parameters:
- NFLOORS, 4: number of floors; floor indices run 0..NFLOORS-1; legal range ≥2.
- MOVE_TICKS, 4: clock cycles needed to travel one floor; must be ≥1.
- DOOR_TICKS, 3: clock cycles the door stays open; must be ≥3 so that a button's registered call drops before the car re-evaluates.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset; synchronous, active-high.
- req  in  NFLOORS  latched call level per floor; bit i high means floor i is requested.
- fb  out  NFLOORS  arrival feedback; one-hot, bit i is high while the door is open at floor i.
- floor  out  FW=$clog2(NFLOORS)  current car floor.
- dir  out  1  travel direction: 1 = up, 0 = down.
- moving  out  1  high while the state is MOVE.
- door_open  out  1  high while the state is DOOR.

Behaviour:
- All outputs are registered.
- Reset takes effect when clr=1 is sampled on a clk rising edge. After that edge:
  - state=IDLE, floor=0, dir=1.
  - fb=0, moving=0, door_open=0, tick counter=0.
  - Reset mid-MOVE or mid-DOOR aborts immediately; no fb pulse is completed.
- Derived signals (combinational from req and floor):
  - above = OR of req[j] for j>floor.
  - below = OR of req[j] for j<floor.
  - here = req[floor].
- IDLE: decided every cycle; the transition takes effect at the next edge.
  - If here: go to DOOR.
  - Else if above and (dir=1 or !below): set dir=1, go to MOVE.
  - Else if below: set dir=0, go to MOVE.
  - Else: stay in IDLE.
- MOVE: counter counts 0..MOVE_TICKS-1. On the edge where counter==MOVE_TICKS-1:
  - floor steps by ±1 according to dir, and the counter resets.
  - Using nf (the new floor): if req[nf], go to DOOR on the same edge.
  - Else if there are requests strictly beyond nf in dir, stay in MOVE.
  - Else go to IDLE.
  - Changes to req at the departure floor during MOVE are ignored.
- DOOR:
  - door_open=1 and fb=one-hot(floor) for exactly DOOR_TICKS cycles, then go to IDLE.
  - dir is preserved, so SCAN continues the prior direction when calls remain ahead.
- Boundaries:
  - floor never leaves the range 0..NFLOORS-1.
  - At floor 0, "below" is always 0; at the top floor, "above" is always 0. Reversal therefore happens only via IDLE.
- fb rules:
  - fb is never high outside DOOR.
  - fb never has more than one bit set.
  - fb drops on the same edge that door_open drops.
- Simultaneous events:
  - A new call at the current floor arriving during DOOR is masked, because the button ignores presses while fb is high.
  - Calls above and below at once in IDLE are resolved by the current dir.
- The minimum IDLE dwell between DOOR and MOVE is 1 cycle.

Decomposition:
- Shared package elevator_pkg holds:
  - state enum {IDLE, MOVE, DOOR};
  - constants DIR_UP=1 and DIR_DOWN=0;
  - the FW width function.
- One natural sub-module, elevator_req_scan: purely combinational.
  - Inputs: req, floor, dir.
  - Outputs: here, above, below, beyond_next.
  - Instantiated once and reused for the MOVE arrival lookahead.

Test Plan:
- Parameters for all scenarios: NFLOORS=4, MOVE_TICKS=4, DOOR_TICKS=3.
- Reset: assert clr for 2 cycles during MOVE toward floor 2 -> after the reset edge, floor=0, dir=1, fb=4'b0000, moving=0, door_open=0.
- Call at current floor: idle at floor 0, req=4'b0001 -> next edge door_open=1, fb=4'b0001 for 3 cycles, then IDLE with fb=0.
- Single trip: from floor 0, req=4'b0100 ->
  - moving=1 one edge later;
  - floor=1 4 cycles after MOVE entry;
  - floor=2 4 cycles after that, with door_open=1 and fb=4'b0100 on that same edge.
- SCAN ordering: car moving up at floor 1, req=4'b1101 -> services floor 2, then 3, then reverses (dir=0) and services floor 0; fb order is 0100, 1000, 0001.
- Direction tie-break: idle at floor 2 with dir=0, req=4'b1001 -> goes down to floor 0 first, then up to 3.
- Top-floor boundary: idle at floor 3 with dir=1, req=4'b0010 -> dir becomes 0, car stops at floor 1; floor never exceeds 3.
